// File: rtl/sysbus_decoder.sv
// Table-driven system-bus decoder and wait-state controller for the 6502 core.
// Optional bus timeout on ack-mode slots: define SYSBUS_TIMEOUT_EN.
module sysbus_decoder #(
  parameter int                           NUM_SLOTS    = 6,
  parameter int                           ADDR_W       = 16,
  parameter int                           DATA_W       = 8,
  parameter logic [NUM_SLOTS*ADDR_W-1:0]  SLOT_BASE    = '0,
  parameter logic [NUM_SLOTS*ADDR_W-1:0]  SLOT_MASK    = '0,
  parameter logic [NUM_SLOTS*4-1:0]       SLOT_WAIT    = '0,
  parameter logic [DATA_W-1:0]            DEFAULT_DATA = 8'hFF,
  parameter int                           TIMEOUT      = 64
) (
  input  logic                        clk25,
  input  logic                        rst,
  input  logic                        cpu_clken,
  input  logic [ADDR_W-1:0]           ab,
  input  logic                        we,
  output logic                        cpu_ready,
  output logic [DATA_W-1:0]           dbi,
  output logic [NUM_SLOTS-1:0]        slot_cs,
  output logic [NUM_SLOTS-1:0]        slot_en,
  output logic                        slot_we,
  input  logic [NUM_SLOTS*DATA_W-1:0] slot_dout,
  input  logic [NUM_SLOTS-1:0]        slot_ack,
  input  logic                        err_clr,
  output logic                        bus_err,
  output logic [ADDR_W-1:0]           err_addr
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2} state_t;

  state_t             state, next_state;
  logic [3:0]         wait_cnt;
  logic [IDX_W-1:0]   idx;
  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic [3:0]         hit_wait;
  logic               sel_valid;
  logic [IDX_W-1:0]   sel_idx;
  logic               ack_sel;
  logic               stall;
  logic               launch;
  logic               abort;

  // Descending scan so the lowest matching slot index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if ((ab & SLOT_MASK[s*ADDR_W +: ADDR_W]) ==
          (SLOT_BASE[s*ADDR_W +: ADDR_W] & SLOT_MASK[s*ADDR_W +: ADDR_W])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(s);
      end
    end
  end

  assign hit_wait  = SLOT_WAIT[{hit_idx, 2'b00} +: 4];
  assign sel_valid = (state == IDLE) ? hit : 1'b1;
  assign sel_idx   = (state == IDLE) ? hit_idx : idx;

  always_comb begin
    slot_cs = '0;
    ack_sel = 1'b0;
    dbi     = DEFAULT_DATA;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (sel_valid && (sel_idx == IDX_W'(s))) begin
        slot_cs[s] = 1'b1;
        if (!abort) begin
          dbi = slot_dout[s*DATA_W +: DATA_W];
        end
      end
      if (idx == IDX_W'(s)) begin
        ack_sel = slot_ack[s];
      end
    end
  end

`ifdef SYSBUS_TIMEOUT_EN
  // The launch strobe counts as strobe 1, so abort fires when the counter shows TIMEOUT-2.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 2);
  logic [7:0]        tmo_cnt;
  logic              bus_err_r;
  logic [ADDR_W-1:0] err_addr_r;
  logic              tmo_hit;

  assign tmo_hit = (tmo_cnt == TO_LAST);
`else
  logic tmo_hit;

  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    next_state = state;
    stall      = 1'b0;
    launch     = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_clken && hit) begin
          launch = 1'b1;
          if (hit_wait == 4'd15) begin
            stall      = 1'b1;
            next_state = ACK;
          end else if (hit_wait != 4'd0) begin
            stall      = 1'b1;
            next_state = WAIT;
          end else begin
            next_state = IDLE;
          end
        end else begin
          next_state = IDLE;
        end
      end
      WAIT: begin
        if (cpu_clken) begin
          if (wait_cnt == 4'd1) begin
            next_state = IDLE;
          end else begin
            stall = 1'b1;
          end
        end else begin
          next_state = WAIT;
        end
      end
      ACK: begin
        if (cpu_clken) begin
          if (ack_sel) begin
            next_state = IDLE;
          end else if (tmo_hit) begin
            abort      = 1'b1;
            next_state = IDLE;
          end else begin
            stall = 1'b1;
          end
        end else begin
          next_state = ACK;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign cpu_ready = cpu_clken & ~stall;
  assign slot_en   = launch ? slot_cs : '0;
  assign slot_we   = we & (|slot_cs);

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      idx      <= '0;
    end else begin
      state <= next_state;
      if (launch) begin
        idx      <= hit_idx;
        wait_cnt <= (hit_wait == 4'd15) ? 4'd0 : hit_wait;
      end else if (state == WAIT && cpu_clken) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

`ifdef SYSBUS_TIMEOUT_EN
  // Timeout counter and sticky error capture; a new abort beats err_clr.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      tmo_cnt    <= 8'd0;
      bus_err_r  <= 1'b0;
      err_addr_r <= '0;
    end else begin
      if (launch) begin
        tmo_cnt <= 8'd0;
      end else if (state == ACK && cpu_clken && !ack_sel) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
      if (abort) begin
        bus_err_r <= 1'b1;
        if (!bus_err_r) begin
          err_addr_r <= ab;
        end
      end else if (err_clr) begin
        bus_err_r <= 1'b0;
      end
    end
  end

  assign bus_err  = bus_err_r;
  assign err_addr = err_addr_r;
`else
  assign bus_err  = 1'b0;
  assign err_addr = '0;
`endif

endmodule

// File: tb/tb_sysbus_decoder.sv
// Directed self-checking bench for sysbus_decoder with a six-slot table.
module tb_sysbus_decoder;

  localparam logic [95:0] BASE = {16'hD000, 16'hB000, 16'hC000, 16'hFF00, 16'h0000, 16'h0000};
  localparam logic [95:0] MASK = {16'hF000, 16'hF000, 16'hF000, 16'hFF00, 16'hF000, 16'h8000};
  localparam logic [23:0] WTAB = {4'd0, 4'd3, 4'd15, 4'd0, 4'd0, 4'd0};

  logic        clk25 = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_clken = 1'b0;
  logic [15:0] ab = 16'hA000;
  logic        we = 1'b0;
  logic        cpu_ready;
  logic [7:0]  dbi;
  logic [5:0]  slot_cs;
  logic [5:0]  slot_en;
  logic        slot_we;
  logic [47:0] slot_dout = {8'h95, 8'h84, 8'h73, 8'hC2, 8'h61, 8'h5A};
  logic [5:0]  slot_ack = 6'b0;
  logic        err_clr = 1'b0;
  logic        bus_err;
  logic [15:0] err_addr;

  int tests = 0;
  int fails = 0;

  sysbus_decoder #(
    .NUM_SLOTS(6), .ADDR_W(16), .DATA_W(8),
    .SLOT_BASE(BASE), .SLOT_MASK(MASK), .SLOT_WAIT(WTAB),
    .DEFAULT_DATA(8'hFF), .TIMEOUT(8)
  ) dut (
    .clk25(clk25), .rst(rst), .cpu_clken(cpu_clken), .ab(ab), .we(we),
    .cpu_ready(cpu_ready), .dbi(dbi), .slot_cs(slot_cs), .slot_en(slot_en),
    .slot_we(slot_we), .slot_dout(slot_dout), .slot_ack(slot_ack),
    .err_clr(err_clr), .bus_err(bus_err), .err_addr(err_addr)
  );

  always #5 clk25 = ~clk25;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise a strobe at the falling edge; outputs are sampled 1 ns later.
  task automatic strobe_on(input logic [15:0] a);
    @(negedge clk25);
    ab = a;
    cpu_clken = 1'b1;
    #1;
  endtask

  task automatic strobe_off();
    @(negedge clk25);
    cpu_clken = 1'b0;
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk25);
    #1;
  endtask

  initial begin
    gap(3);
    check("reset_ready", 32'(cpu_ready), 32'h0);
    check("reset_en", 32'(slot_en), 32'h0);
    check("reset_bus_err", 32'(bus_err), 32'h0);
    check("reset_err_addr", 32'(err_addr), 32'h0);
    @(negedge clk25);
    rst = 1'b0;
    gap(2);

    // ROM read, zero wait states
    strobe_on(16'hFF1A);
    check("rom_cs", 32'(slot_cs), 32'h04);
    check("rom_ready", 32'(cpu_ready), 32'h1);
    check("rom_dbi", 32'(dbi), 32'hC2);
    check("rom_en", 32'(slot_en), 32'h04);
    check("rom_we", 32'(slot_we), 32'h0);
    strobe_off();
    check("rom_ready_noclken", 32'(cpu_ready), 32'h0);
    check("rom_en_noclken", 32'(slot_en), 32'h0);

    // Unmapped read
    strobe_on(16'hA000);
    check("unmap_cs", 32'(slot_cs), 32'h0);
    check("unmap_dbi", 32'(dbi), 32'hFF);
    check("unmap_ready", 32'(cpu_ready), 32'h1);
    check("unmap_en", 32'(slot_en), 32'h0);
    strobe_off();

    // Overlapping slots 0 and 1: lowest index wins; write qualifies slot_we
    we = 1'b1;
    strobe_on(16'h0123);
    check("ovl_cs", 32'(slot_cs), 32'h01);
    check("ovl_dbi", 32'(dbi), 32'h5A);
    check("ovl_we", 32'(slot_we), 32'h1);
    strobe_off();
    we = 1'b0;

    // Three wait states, strobe every 4 clocks
    strobe_on(16'hB010);
    check("w3_s1_ready", 32'(cpu_ready), 32'h0);
    check("w3_s1_en", 32'(slot_en), 32'h10);
    strobe_off();
    check("w3_hold_cs", 32'(slot_cs), 32'h10);
    gap(2);
    for (int k = 2; k <= 3; k++) begin
      strobe_on(16'hB010);
      check($sformatf("w3_s%0d_ready", k), 32'(cpu_ready), 32'h0);
      check($sformatf("w3_s%0d_en", k), 32'(slot_en), 32'h0);
      strobe_off();
      gap(2);
    end
    strobe_on(16'hB010);
    check("w3_s4_ready", 32'(cpu_ready), 32'h1);
    check("w3_s4_en", 32'(slot_en), 32'h0);
    check("w3_s4_dbi", 32'(dbi), 32'h84);
    strobe_off();
    gap(2);
    strobe_on(16'hA000);
    check("w3_after_idle", 32'(cpu_ready), 32'h1);
    strobe_off();

    // Ack slot: a lone ack pulse between strobes is ignored, then ack before strobe 6
    strobe_on(16'hC123);
    check("ack_s1_ready", 32'(cpu_ready), 32'h0);
    check("ack_s1_en", 32'(slot_en), 32'h08);
    strobe_off();
    slot_ack = 6'h08;
    @(negedge clk25);
    slot_ack = 6'h00;
    gap(1);
    for (int k = 2; k <= 5; k++) begin
      strobe_on(16'hC123);
      check($sformatf("ack_s%0d_ready", k), 32'(cpu_ready), 32'h0);
      check($sformatf("ack_s%0d_cs", k), 32'(slot_cs), 32'h08);
      strobe_off();
      gap(1);
    end
    slot_ack = 6'h08;
    strobe_on(16'hC123);
    check("ack_s6_ready", 32'(cpu_ready), 32'h1);
    check("ack_s6_dbi", 32'(dbi), 32'h73);
    check("ack_s6_en", 32'(slot_en), 32'h0);
    strobe_off();
    slot_ack = 6'h00;
    gap(1);

`ifdef SYSBUS_TIMEOUT_EN
    // Timeout after 8 strobes with no ack
    for (int k = 1; k <= 7; k++) begin
      strobe_on(16'hC800);
      check($sformatf("to1_s%0d_ready", k), 32'(cpu_ready), 32'h0);
      strobe_off();
    end
    strobe_on(16'hC800);
    check("to1_s8_ready", 32'(cpu_ready), 32'h1);
    check("to1_s8_dbi", 32'(dbi), 32'hFF);
    strobe_off();
    check("to1_bus_err", 32'(bus_err), 32'h1);
    check("to1_err_addr", 32'(err_addr), 32'hC800);
    for (int k = 1; k <= 7; k++) begin
      strobe_on(16'hC900);
      strobe_off();
    end
    strobe_on(16'hC900);
    check("to2_s8_ready", 32'(cpu_ready), 32'h1);
    strobe_off();
    check("to2_bus_err", 32'(bus_err), 32'h1);
    check("to2_err_addr", 32'(err_addr), 32'hC800);
    @(negedge clk25);
    err_clr = 1'b1;
    @(negedge clk25);
    err_clr = 1'b0;
    #1;
    check("errclr_bus_err", 32'(bus_err), 32'h0);
`else
    // Without the timeout an ack-mode access waits past 8 strobes
    for (int k = 1; k <= 10; k++) begin
      strobe_on(16'hC800);
      check($sformatf("noto_s%0d_ready", k), 32'(cpu_ready), 32'h0);
      strobe_off();
    end
    check("noto_bus_err", 32'(bus_err), 32'h0);
    check("noto_err_addr", 32'(err_addr), 32'h0);
    slot_ack = 6'h08;
    strobe_on(16'hC800);
    check("noto_ack_ready", 32'(cpu_ready), 32'h1);
    strobe_off();
    slot_ack = 6'h00;
`endif

    // Reset while WAIT holds count 2
    strobe_on(16'hB010);
    strobe_off();
    strobe_on(16'hB010);
    check("rst_pre_ready", 32'(cpu_ready), 32'h0);
    strobe_off();
    @(negedge clk25);
    rst = 1'b1;
    ab = 16'hA000;
    @(negedge clk25);
    rst = 1'b0;
    gap(1);
    check("rst_cs_idle", 32'(slot_cs), 32'h0);
    strobe_on(16'hA000);
    check("rst_ready", 32'(cpu_ready), 32'h1);
    check("rst_en", 32'(slot_en), 32'h0);
    check("rst_bus_err", 32'(bus_err), 32'h0);
    strobe_off();
    strobe_on(16'hFF1A);
    check("rst_rom_ready", 32'(cpu_ready), 32'h1);
    check("rst_rom_en", 32'(slot_en), 32'h04);
    strobe_off();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sysbus_decoder.md
# sysbus_decoder

Parametrised system-bus decoder and wait-state controller between the 6502 core and its memory/peripheral slots. It replaces the fixed chip-select equations and fixed-priority read mux in the top level with a table-driven decoder: per-slot base/mask matching, per-slot fixed wait states or ack-based handshaking, and generation of the CPU `ready` strobe. An optional bus timeout turns a hung acknowledge into a defined completion.

## Interface
- `NUM_SLOTS`, 6: number of decoded slots, 1..16.
- `ADDR_W`, 16: address width.
- `DATA_W`, 8: data width.
- `SLOT_BASE`, all 0: packed `NUM_SLOTS*ADDR_W`; slot s base address at bits `[s*ADDR_W +: ADDR_W]`.
- `SLOT_MASK`, all 0: packed `NUM_SLOTS*ADDR_W`; 1 = bit compared.
- `SLOT_WAIT`, all 0: packed `NUM_SLOTS*4`; 0..14 = fixed extra strobes; 15 = wait for `slot_ack`.
- `DEFAULT_DATA`, 8'hFF: read data for unmapped or timed-out accesses.
- `TIMEOUT`, 64: strobes before an ack-mode access is aborted, 2..255.

Ports:
- `clk25` in 1: master clock.
- `rst` in 1: reset; one clock, asynchronous, active-high.
- `cpu_clken` in 1: CPU enable strobe.
- `ab` in ADDR_W: CPU address.
- `we` in 1: CPU write.
- `cpu_ready` out 1: to CPU `ready`.
- `dbi` out DATA_W: read data to CPU.
- `slot_cs` out NUM_SLOTS: one-hot chip select, held for the whole access.
- `slot_en` out NUM_SLOTS: one-cycle launch pulse (side-effect enable).
- `slot_we` out 1: `we` qualified by any `slot_cs`.
- `slot_dout` in NUM_SLOTS*DATA_W: per-slot read data.
- `slot_ack` in NUM_SLOTS: completion for ack-mode slots.
- `err_clr` in 1: clears `bus_err`.
- `bus_err` out 1: sticky timeout flag.
- `err_addr` out ADDR_W: address of the first timed-out access.

## Operation
- Match: slot s hits when `(ab & MASK_s) == (BASE_s & MASK_s)`. The lowest index wins. No hit means unmapped: `slot_cs` = 0 and `dbi` = `DEFAULT_DATA`.
- `dbi` is a combinational mux of `slot_dout` for the selected slot; in `ACK`/`WAIT` the mux uses the registered slot index.
- FSM states: `IDLE`, `WAIT` (fixed count), `ACK` (waiting on `slot_ack`).
- `IDLE`:
  - On a strobe (`cpu_clken`=1) that hits slot s, `slot_en[s]`=1 for that cycle.
  - W = `SLOT_WAIT[s]`. W=0: `cpu_ready`=1 and stay in `IDLE`.
  - 1≤W≤14: `cpu_ready`=0, load counter with W, latch s, go to `WAIT`.
  - W=15: `cpu_ready`=0, clear timeout counter, latch s, go to `ACK`.
- `WAIT`:
  - Each strobe decrements the counter, with `cpu_ready`=0.
  - On the strobe where the counter equals 1, `cpu_ready`=1 and the FSM returns to `IDLE`.
  - Access length is W+1 strobes.
- `ACK`:
  - `slot_ack[s]` is sampled on strobes only.
  - A strobe with ack=1 gives `cpu_ready`=1 and returns to `IDLE`.
  - Acks between strobes are ignored; a slot holds ack until its `slot_cs` drops.
- `cpu_ready` = `cpu_clken` & ~stall. It is never high while `cpu_clken`=0.
- `slot_en` fires exactly once per access, on the launch strobe, never on completion strobes.
- `err_clr` and a new timeout in the same cycle: set wins.

## Timing
- Reset values: state `IDLE`, counters 0, `bus_err`=0, `err_addr`=0, `slot_en`=0.
- `cpu_ready` follows `cpu_clken` combinationally in `IDLE`.
- `slot_cs` is combinational from `ab` in `IDLE` and registered-index-driven in `WAIT`/`ACK`. The address is stable because the CPU is stalled.
- Reset mid-access: the FSM is forced to `IDLE` immediately and `cpu_ready` resumes following `cpu_clken`. No `slot_en` is issued on the next strobe unless a new hit occurs.
- Unmapped accesses never stall.

## Configuration
- `SYSBUS_TIMEOUT_EN` defined:
  - In `ACK`, each strobe increments the timeout counter.
  - On the strobe where it reaches `TIMEOUT` without ack, the access completes with `cpu_ready`=1 and `dbi` = `DEFAULT_DATA`.
  - On that abort, `bus_err` is set; `err_addr` captures `ab` only if `bus_err` was 0.
- Undefined:
  - Ack-mode accesses wait indefinitely.
  - `bus_err` is tied 0 and `err_addr` is tied 0.
  - Timeout counter logic is absent.

## Test plan
- Default table (RAM 0x0000/0x8000 W=0, ROM 0xFF00/0xFF00 W=0), read 0xFF1A -> `slot_cs`=ROM one-hot, `cpu_ready`=`cpu_clken`, `dbi`=ROM `slot_dout`; read 0xA000 -> `dbi`=0xFF, no `slot_cs`.
- Overlap: slot0 0x0000/0x8000 and slot1 0x0000/0xF000, read 0x0123 -> slot0 selected.
- Slot W=3, strobe every 4 clocks -> `cpu_ready` low on strobes 1-3, high on strobe 4; `slot_en` pulses once on strobe 1.
- Ack slot, ack asserted after 5 strobes -> ready on the first strobe with ack=1; an ack pulse between strobes alone is ignored.
- With `SYSBUS_TIMEOUT_EN` and `TIMEOUT`=8, ack never given at address 0xC800 -> ready on strobe 8, `dbi`=0xFF, `bus_err`=1, `err_addr`=0xC800. A second timeout at 0xC900 leaves `err_addr`=0xC800. `err_clr` -> `bus_err`=0.
- `rst` pulse while in `WAIT` with count 2 -> next strobe `cpu_ready`=1 (`IDLE`), `bus_err`=0, no spurious `slot_en`.
